// File: rtl/vga_pkg.sv
// Shared VGA timing constants, decode bundle and colour helpers used by the
// raster generator and anything that needs to agree with its timing.
package vga_pkg;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480@60, 25 MHz-class pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam int VGA640_H_TOTAL  = vga_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
    localparam int VGA640_V_TOTAL  = vga_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);

    // 800x600@72, 50 MHz-class pixel clock
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 56;
    localparam int VGA800_H_SYNC   = 120;
    localparam int VGA800_H_BP     = 64;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 37;
    localparam int VGA800_V_SYNC   = 6;
    localparam int VGA800_V_BP     = 23;
    localparam int VGA800_H_TOTAL  = vga_total(VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP);
    localparam int VGA800_V_TOTAL  = vga_total(VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC, VGA800_V_BP);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } vga_dec_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    function automatic rgb332_t rgb_split(input logic [7:0] px);
        return rgb332_t'(px);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-memory read port: the generator drives the address, the line buffer
// answers with the pixel word a fixed number of cycles later.
interface vga_timing_gen_if #(
    parameter int AW   = 11,
    parameter int PX_W = 8
);
    logic [AW-1:0]   PxAddr;
    logic [PX_W-1:0] PxData;

    modport master (output PxAddr, input PxData);
    modport slave  (input PxAddr, output PxData);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter over active/front-porch/sync/back-porch
// segments with decoded active and sync windows.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int  ACTIVE = VGA640_H_ACTIVE,
    parameter int  FP     = VGA640_H_FP,
    parameter int  SYNC   = VGA640_H_SYNC,
    parameter int  BP     = VGA640_H_BP,
    localparam int TOTAL  = vga_total(ACTIVE, FP, SYNC, BP),
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         clk100,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_act
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_segment
        $error("vga_axis_counter: every segment length must be at least 1");
    end

    assign wrap     = inc && (cnt == LAST);
    assign active   = (cnt < ACT_END);
    assign sync_act = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel divider, H/V counters, line-buffer
// address, and an output stage delay-matched to the pixel-memory latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int  CLK_DIV    = 4,
    parameter int  H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int  H_FP       = VGA640_H_FP,
    parameter int  H_SYNC     = VGA640_H_SYNC,
    parameter int  H_BP       = VGA640_H_BP,
    parameter int  V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int  V_FP       = VGA640_V_FP,
    parameter int  V_SYNC     = VGA640_V_SYNC,
    parameter int  V_BP       = VGA640_V_BP,
    parameter bit  HS_POL     = 1'b0,
    parameter bit  VS_POL     = 1'b0,
    parameter int  R_W        = 3,
    parameter int  G_W        = 3,
    parameter int  B_W        = 2,
    parameter int  LB_SEL_W   = 1,
    parameter int  PX_LATENCY = 1,
    localparam int PX_W       = R_W + G_W + B_W,
    localparam int H_TOTAL    = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL    = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL)
) (
    input  logic                   clk100,
    input  logic                   rst,
    vga_timing_gen_if.master       px,
    output logic [R_W-1:0]         R,
    output logic [G_W-1:0]         G,
    output logic [B_W-1:0]         B,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   frame_start,
    output logic                   line_start,
    output logic [HW-1:0]          Pixel,
    output logic [VW-1:0]          Line
);

    localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PX_LATENCY < 0 || PX_LATENCY > 4) begin : g_bad_latency
        $error("vga_timing_gen: PX_LATENCY must be within 0..4");
    end
    if ($bits(px.PxData) != PX_W) begin : g_bad_px_w
        $error("vga_timing_gen: PxData width does not match R_W+G_W+B_W");
    end
    if (LB_SEL_W < 1 || LB_SEL_W > VW || $bits(px.PxAddr) != LB_SEL_W + HW) begin : g_bad_addr
        $error("vga_timing_gen: PxAddr width or LB_SEL_W is inconsistent with the raster");
    end

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             h_wrap, h_active, h_sync_act;
    logic             v_wrap, v_active, v_sync_act;
    vga_dec_t         dec;
    vga_dec_t         dec_d;

    assign tick = (div == DIV_LAST);

    // Divider: with CLK_DIV=1 it sits at 0 and tick is permanently high.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_hcnt (
        .clk100   (clk100),
        .rst      (rst),
        .inc      (tick),
        .cnt      (Pixel),
        .wrap     (h_wrap),
        .active   (h_active),
        .sync_act (h_sync_act)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_vcnt (
        .clk100   (clk100),
        .rst      (rst),
        .inc      (h_wrap),
        .cnt      (Line),
        .wrap     (v_wrap),
        .active   (v_active),
        .sync_act (v_sync_act)
    );

    // The frame wrap is only reachable through the last pixel of a line.
    assert property (@(posedge clk100) disable iff (rst) v_wrap |-> h_wrap);

    assign px.PxAddr = {Line[LB_SEL_W-1:0], Pixel};

    // Strobes qualify on div==0 so they last one clk100 cycle, not a whole pixel.
    always_comb begin
        dec     = '0;
        dec.act = h_active && v_active;
        dec.hs  = h_sync_act;
        dec.vs  = v_sync_act;
        dec.ls  = (Pixel == '0) && (div == '0);
        dec.fs  = (Pixel == '0) && (Line == '0) && (div == '0);
    end

    if (PX_LATENCY == 0) begin : g_no_delay
        assign dec_d = dec;
    end else begin : g_delay
        vga_dec_t stage [PX_LATENCY];

        always_ff @(posedge clk100 or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PX_LATENCY; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= dec;
                for (int i = 1; i < PX_LATENCY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dec_d = stage[PX_LATENCY-1];
    end

    // Output register: the delayed decode meets the returned pixel word here.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            R           <= '0;
            G           <= '0;
            B           <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            if (dec_d.act) begin
                {R, G, B} <= px.PxData;
            end else begin
                {R, G, B} <= '0;
            end
            hsync       <= dec_d.hs ? HS_POL : ~HS_POL;
            vsync       <= dec_d.vs ? VS_POL : ~VS_POL;
            de          <= dec_d.act;
            frame_start <= dec_d.fs;
            line_start  <= dec_d.ls;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster with a divided pixel
// clock, a 3-cycle pixel memory model and a mid-frame reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CLK_DIV   = 3;
    localparam int H_A       = 8;
    localparam int H_F       = 1;
    localparam int H_S       = 2;
    localparam int H_B       = 1;
    localparam int V_A       = 4;
    localparam int V_F       = 1;
    localparam int V_S       = 1;
    localparam int V_B       = 1;
    localparam int H_T       = 12;
    localparam int V_T       = 7;
    localparam int LAT       = 3;
    localparam int HW        = 4;
    localparam int VW        = 3;
    localparam int AW        = 1 + HW;
    localparam bit HS_POL    = 1'b1;
    localparam bit VS_POL    = 1'b0;
    localparam int LINE_CYC  = H_T * CLK_DIV;
    localparam int FRAME_CYC = LINE_CYC * V_T;

    typedef struct packed {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       ls;
    } exp_t;

    logic          clk100 = 1'b0;
    logic          rst    = 1'b1;
    logic [2:0]    R;
    logic [2:0]    G;
    logic [1:0]    B;
    logic          hsync, vsync, de, frame_start, line_start;
    logic [HW-1:0] Pixel;
    logic [VW-1:0] Line;

    int   n_compared = 0;
    int   n_mismatch = 0;
    exp_t sb [$];
    int   m_div, m_pix, m_line;

    vga_timing_gen_if #(.AW(AW), .PX_W(8)) px ();

    vga_timing_gen #(
        .CLK_DIV    (CLK_DIV),
        .H_ACTIVE   (H_A),
        .H_FP       (H_F),
        .H_SYNC     (H_S),
        .H_BP       (H_B),
        .V_ACTIVE   (V_A),
        .V_FP       (V_F),
        .V_SYNC     (V_S),
        .V_BP       (V_B),
        .HS_POL     (HS_POL),
        .VS_POL     (VS_POL),
        .R_W        (3),
        .G_W        (3),
        .B_W        (2),
        .LB_SEL_W   (1),
        .PX_LATENCY (LAT)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .px          (px),
        .R           (R),
        .G           (G),
        .B           (B),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .line_start  (line_start),
        .Pixel       (Pixel),
        .Line        (Line)
    );

    always #5 clk100 = ~clk100;

    function automatic logic [7:0] pxHash(input logic [AW-1:0] a);
        logic [7:0] x;
        x = {3'b000, a};
        return (x * 8'd37) ^ 8'h5A ^ {x[1:0], 6'b000000};
    endfunction

    // Pixel memory: answers each address with its hash LAT cycles later.
    logic [7:0] mem_pipe [LAT] = '{default: 8'h00};
    always @(posedge clk100) begin
        mem_pipe[0] <= pxHash(px.PxAddr);
        for (int i = 1; i < LAT; i++) begin
            mem_pipe[i] <= mem_pipe[i-1];
        end
    end
    assign px.PxData = mem_pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_level, input int hold_cycles);
        @(posedge clk100);
        #2;
        rst = rst_level;
        repeat (hold_cycles) @(posedge clk100);
    endtask

    // Monitor: predicts each counter state, queues the output it must produce
    // LAT+1 cycles later, and checks strobe spacing and sync windows.
    initial begin : monitor
        exp_t       e, cur;
        rgb332_t    s;
        logic [AW-1:0] addr;
        int         cyc, since_rel, last_fs, last_ls, hs_rise;
        bit         seen_fs, ls_ok, hs_ok;
        logic       hs_prev;
        cyc = 0; since_rel = 0; last_fs = 0; last_ls = 0; hs_rise = 0;
        seen_fs = 0; ls_ok = 0; hs_ok = 0; hs_prev = 1'b0;
        m_div = 0; m_pix = 0; m_line = 0;
        forever begin
            @(negedge clk100);
            cyc++;
            if (rst) begin
                sb.delete();
                m_div = 0; m_pix = 0; m_line = 0;
                since_rel = 0; seen_fs = 0; ls_ok = 0; hs_ok = 0;
                checkOutput("rst_rgb",   {R, G, B},   32'h0);
                checkOutput("rst_hsync", hsync,       !HS_POL);
                checkOutput("rst_vsync", vsync,       !VS_POL);
                checkOutput("rst_de",    de,          0);
                checkOutput("rst_fs",    frame_start, 0);
                checkOutput("rst_ls",    line_start,  0);
                checkOutput("rst_pixel", Pixel,       0);
                checkOutput("rst_line",  Line,        0);
                hs_prev = hsync;
            end else begin
                addr = {1'(m_line), 4'(m_pix)};
                checkOutput("pixel",  Pixel,     m_pix);
                checkOutput("line",   Line,      m_line);
                checkOutput("pxaddr", px.PxAddr, addr);

                cur    = '0;
                cur.de = (m_pix < H_A) && (m_line < V_A);
                cur.hs = (m_pix >= H_A + H_F) && (m_pix < H_A + H_F + H_S);
                cur.vs = (m_line >= V_A + V_F) && (m_line < V_A + V_F + V_S);
                cur.fs = (m_pix == 0) && (m_line == 0) && (m_div == 0);
                cur.ls = (m_pix == 0) && (m_div == 0);
                cur.rgb = cur.de ? pxHash(addr) : 8'h00;
                sb.push_back(cur);

                if (sb.size() > LAT + 1) e = sb.pop_front();
                else e = '0;
                s = rgb_split(e.rgb);
                checkOutput("R",     R,           s.r);
                checkOutput("G",     G,           s.g);
                checkOutput("B",     B,           s.b);
                checkOutput("hsync", hsync,       e.hs ? HS_POL : !HS_POL);
                checkOutput("vsync", vsync,       e.vs ? VS_POL : !VS_POL);
                checkOutput("de",    de,          e.de);
                checkOutput("fs",    frame_start, e.fs);
                checkOutput("ls",    line_start,  e.ls);

                if (frame_start) begin
                    if (!seen_fs) checkOutput("fs_first", since_rel, LAT + 1);
                    else          checkOutput("fs_period", cyc - last_fs, FRAME_CYC);
                    seen_fs = 1;
                    last_fs = cyc;
                end
                if (line_start) begin
                    if (ls_ok) checkOutput("ls_period", cyc - last_ls, LINE_CYC);
                    ls_ok   = 1;
                    last_ls = cyc;
                end
                if ((hsync == HS_POL) && (hs_prev != HS_POL) && ls_ok) begin
                    checkOutput("hs_offset", cyc - last_ls, (H_A + H_F) * CLK_DIV);
                    hs_rise = cyc;
                    hs_ok   = 1;
                end
                if ((hsync != HS_POL) && (hs_prev == HS_POL) && hs_ok) begin
                    checkOutput("hs_width", cyc - hs_rise, H_S * CLK_DIV);
                end
                hs_prev = hsync;
                since_rel++;

                if (m_div == CLK_DIV - 1) begin
                    m_div = 0;
                    if (m_pix == H_T - 1) begin
                        m_pix  = 0;
                        m_line = (m_line == V_T - 1) ? 0 : m_line + 1;
                    end else begin
                        m_pix++;
                    end
                end else begin
                    m_div++;
                end
            end
        end
    end

    initial begin : stimulus
        bit found;
        $display("[TB] small raster %0dx%0d, CLK_DIV=%0d, PX_LATENCY=%0d", H_T, V_T, CLK_DIV, LAT);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 2 * FRAME_CYC + 20);

        found = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
            @(posedge clk100);
            #2;
            if (Line == 3'd2 && Pixel == 4'd5) found = 1;
        end
        checkOutput("midframe_reach", found, 1);

        rst = 1'b1;
        #1;
        checkOutput("async_rgb",   {R, G, B}, 32'h0);
        checkOutput("async_hsync", hsync,     !HS_POL);
        checkOutput("async_vsync", vsync,     !VS_POL);
        checkOutput("async_de",    de,        0);
        checkOutput("async_pixel", Pixel,     0);
        checkOutput("async_line",  Line,      0);

        applyStimulus(1'b0, 2 * FRAME_CYC + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
